// File: rtl/key_pkg.sv
// Shared definitions for the key debounce block: FSM state encoding and
// default timing constants (20 ms debounce, 1 s long press at 50 MHz).
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_DOWN       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } key_state_t;

  localparam int unsigned DEBOUNCE_CYC_DEF = 1_000_000;
  localparam int unsigned LONG_CYC_DEF     = 50_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-FF synchronizer, debounce FSM and press/release pulses.
// Optional long-press detector when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned ACTIVE_LOW   = 1
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  // Pin level when the key is not pressed
  localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_act;
  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_press;
  logic             w_press_nxt;
  logic             r_release;
  logic             w_release_nxt;

  // Synchronizer, reset to the released pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= REL_LVL;
      r_sync2 <= REL_LVL;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_act = r_sync2 ^ REL_LVL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Debounce next-state: counter restarts on every state change
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_act) begin
          w_state_nxt = ST_PRESS_DB;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!w_act) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_DOWN;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DOWN: begin
        if (!w_act) begin
          w_state_nxt = ST_RELEASE_DB;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_DB: begin
        if (w_act) begin
          w_state_nxt = ST_DOWN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
          w_level_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_CYC);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

  logic [LONG_W-1:0] r_lcnt;
  logic [LONG_W-1:0] w_lcnt_nxt;
  logic              r_ldone;
  logic              w_ldone_nxt;
  logic              r_long;
  logic              w_long_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcnt  <= '0;
      r_ldone <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_lcnt  <= w_lcnt_nxt;
      r_ldone <= w_ldone_nxt;
      r_long  <= w_long_nxt;
    end
  end

  // Held-time counter: cleared on a real press, survives aborted releases
  always_comb begin
    w_lcnt_nxt  = r_lcnt;
    w_ldone_nxt = r_ldone;
    w_long_nxt  = 1'b0;
    if (r_state == ST_PRESS_DB && w_state_nxt == ST_DOWN) begin
      w_lcnt_nxt  = '0;
      w_ldone_nxt = 1'b0;
    end else if ((r_state == ST_DOWN || r_state == ST_RELEASE_DB) && !r_ldone) begin
      if (r_lcnt == LONG_LAST) begin
        w_long_nxt  = 1'b1;
        w_ldone_nxt = 1'b1;
      end else begin
        w_lcnt_nxt = r_lcnt + LONG_W'(1);
      end
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounced key inputs: KEY_NUM independent channels of key_debounce_ch.
// Define KEY_LONG_PRESS_EN to enable the key_long pulse output.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM      = 2,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  // Reject configurations the counters cannot represent
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYC must be at least 2");
  end
  if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
    $error("key_debounce: LONG_CYC must exceed DEBOUNCE_CYC");
  end

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .ACTIVE_LOW  (ACTIVE_LOW)
`ifdef KEY_LONG_PRESS_EN
      ,
      .LONG_CYC    (LONG_CYC)
`endif
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_key    (key_in[g]),
      .o_level  (key_level[g]),
      .o_press  (key_press[g]),
      .o_release(key_release[g]),
      .o_long   (key_long[g])
    );
  end

endmodule
